// File: rtl/godai_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | godai_mem_pkg                                                        |
// | Shared types, widths and the range check for the data-mem responder. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package godai_mem_pkg;

   localparam int BE_WIDTH      = 4;
   localparam int LAT_CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_state_e;

   // 33-bit compare so a window ending at the top of the address space cannot wrap
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned depth_words);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + ({1'b0, 32'(depth_words)} << 2);
      return (a >= lo) && (a < hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/godai_data_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | godai_data_mem_responder_if                                          |
// | req/gnt/rvalid data memory bus between the core LSU and a responder. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface godai_data_mem_responder_if;
   import godai_mem_pkg::*;

   logic                data_req_i;
   logic                data_gnt_o;
   logic                data_rvalid_o;
   logic                data_we_i;
   logic [BE_WIDTH-1:0] data_be_i;
   logic [31:0]         data_addr_i;
   logic [31:0]         data_wdata_i;
   logic [31:0]         data_rdata_o;
   logic                data_err_o;

   modport master (
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );

   modport slave (
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );

endinterface
`default_nettype wire

// File: rtl/godai_sp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | godai_sp_ram                                                         |
// | Single-port word RAM, byte-enabled sync write, sync read, no reset.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module godai_sp_ram
   import godai_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [BE_WIDTH-1:0] be,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/godai_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | godai_data_mem_responder                                             |
// | Data-port responder: one outstanding access, fixed response latency. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module godai_data_mem_responder
   import godai_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned LATENCY     = 1
) (
   input  logic clk,
   input  logic rst_n,
   godai_data_mem_responder_if.slave bus
);

   localparam int unsigned              c_addr_w   = $clog2(DEPTH_WORDS);
   localparam logic [LAT_CNT_WIDTH-1:0] c_lat_load = LAT_CNT_WIDTH'(LATENCY - 1);

   resp_state_e               state;
   logic [LAT_CNT_WIDTH-1:0]  lat_cnt;
   logic                      rvalid_q;
   logic                      we_q;
   logic                      in_range_q;
   logic [BE_WIDTH-1:0]       be_q;
   logic [31:0]               addr_q;

   logic                      gnt;
   logic                      in_range;
   logic                      ram_en;
   logic [31:0]               offset;
   logic [c_addr_w-1:0]       index;
   logic [31:0]               ram_rdata;
   logic                      unused_ok;

   // Grant is also masked by rst_n so it stays low while reset is held
   assign gnt      = bus.data_req_i && rst_n && (state == IDLE || state == RESP);
   assign in_range = addr_in_range(bus.data_addr_i, BASE_ADDR, DEPTH_WORDS);
   assign offset   = bus.data_addr_i - BASE_ADDR;
   assign index    = offset[c_addr_w+1:2];
   assign ram_en   = gnt && in_range && (bus.data_be_i != '0);

   godai_sp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (c_addr_w)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (bus.data_we_i),
      .be    (bus.data_be_i),
      .addr  (index),
      .wdata (bus.data_wdata_i),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         rvalid_q   <= 1'b0;
         we_q       <= 1'b0;
         in_range_q <= 1'b0;
         be_q       <= '0;
         addr_q     <= '0;
      end else begin
         case (state)
            IDLE, RESP: begin
               if (gnt) begin
                  we_q       <= bus.data_we_i;
                  be_q       <= bus.data_be_i;
                  addr_q     <= bus.data_addr_i;
                  in_range_q <= in_range;
                  if (LATENCY == 1) begin
                     state    <= RESP;
                     rvalid_q <= 1'b1;
                     lat_cnt  <= '0;
                  end else begin
                     state    <= WAIT;
                     rvalid_q <= 1'b0;
                     lat_cnt  <= c_lat_load;
                  end
               end else begin
                  state    <= IDLE;
                  rvalid_q <= 1'b0;
               end
            end
            WAIT: begin
               if (lat_cnt <= LAT_CNT_WIDTH'(1)) begin
                  state    <= RESP;
                  rvalid_q <= 1'b1;
                  lat_cnt  <= '0;
               end else begin
                  lat_cnt  <= lat_cnt - LAT_CNT_WIDTH'(1);
               end
            end
            default: begin
               state    <= IDLE;
               rvalid_q <= 1'b0;
               lat_cnt  <= '0;
            end
         endcase
      end
   end

   // Response fields are qualified by rvalid so the bus reads 0 between responses
   assign bus.data_gnt_o    = gnt;
   assign bus.data_rvalid_o = rvalid_q;
   assign bus.data_err_o    = rvalid_q && !in_range_q;
   assign bus.data_rdata_o  = (rvalid_q && in_range_q && !we_q && (be_q != '0)) ? ram_rdata : '0;

   assign unused_ok = &{1'b0, addr_q, offset};

endmodule
`default_nettype wire
